// File: rtl/display_mux_ctrl.sv
// ---------------------------------------------------------------------------
// display_mux_ctrl
//
// Drives an eight-digit multiplexed seven-segment display, one digit at a
// time. Each digit slot lasts PRESCALE clock cycles. A new 32-bit value is
// captured into a pending register on load. It is copied into the display
// register only at the end of a full frame, so a frame never mixes old and
// new digits. Each digit can be blanked, blinked or given a decimal point.
//
// Parameters
//   PRESCALE     clock cycles per digit slot (2..65535)
//   BLINK_SLOTS  digit slots per blink half-period (8..65535)
//
// Ports
//   clock     in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   value     in   [31:0] eight 4-bit digit codes, digit 0 in bits [3:0]
//   load      in   single-cycle capture request for value
//   digit_en  in   [7:0] per-digit enable, 0 forces the digit dark
//   point     in   [7:0] per-digit decimal point request, 1 = lit
//   blink_en  in   [7:0] per-digit blink request
//   busy      out  high while a captured value waits for its frame commit
//   nibble    out  [3:0] code of the active digit for the segment LUT
//   anode     out  [7:0] digit drive, active low, bit k = digit k
//   dp        out  decimal point drive, active low
// ---------------------------------------------------------------------------
module display_mux_ctrl #(
  parameter int unsigned PRESCALE    = 10000,
  parameter int unsigned BLINK_SLOTS = 256
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] value,
  input  logic        load,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  point,
  input  logic [7:0]  blink_en,
  output logic        busy,
  output logic [3:0]  nibble,
  output logic [7:0]  anode,
  output logic        dp
);

  localparam logic [15:0] PrescMax = 16'(PRESCALE - 1);
  localparam logic [15:0] BlinkMax = 16'(BLINK_SLOTS - 1);
  localparam logic [31:0] AllBlank = 32'hEEEE_EEEE;
  localparam logic [3:0]  BlankCode = 4'hE;

  logic [15:0] prescCnt_q, prescCnt_d;
  logic [2:0]  slotIdx_q, slotIdx_d;
  logic [15:0] blinkCnt_q, blinkCnt_d;
  logic        blinkOn_q, blinkOn_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] display_q, display_d;
  logic        busy_q, busy_d;
  logic [7:0]  anode_q, anode_d;
  logic [3:0]  nibble_q, nibble_d;
  logic        dp_q, dp_d;

  logic tick;
  logic frameEnd;
  logic visible;

  assign tick     = (prescCnt_q == PrescMax);
  assign frameEnd = tick && (slotIdx_q == 3'd7);

  // Slot timing: the prescaler produces one tick per slot, the slot index
  // walks the eight digits, and the blink counter flips the blink phase
  // every BLINK_SLOTS ticks.
  always_comb begin
    prescCnt_d = prescCnt_q + 16'd1;
    slotIdx_d  = slotIdx_q;
    blinkCnt_d = blinkCnt_q;
    blinkOn_d  = blinkOn_q;
    if (tick) begin
      prescCnt_d = 16'd0;
      slotIdx_d  = slotIdx_q + 3'd1;
      if (blinkCnt_q == BlinkMax) begin
        blinkCnt_d = 16'd0;
        blinkOn_d  = ~blinkOn_q;
      end else begin
        blinkCnt_d = blinkCnt_q + 16'd1;
      end
    end
  end

  // Load/commit handshake. The commit reads the old pending value, so a
  // load landing on the commit edge keeps its new value pending and busy
  // stays set for the next frame.
  always_comb begin
    pending_d = pending_q;
    display_d = display_q;
    busy_d    = busy_q;
    if (frameEnd && busy_q) begin
      display_d = pending_q;
      busy_d    = 1'b0;
    end
    if (load) begin
      pending_d = value;
      busy_d    = 1'b1;
    end
  end

  // Output stage: decode the current slot into one anode, its nibble and
  // decimal point. Enables are applied live so they act on the next update.
  always_comb begin
    visible  = digit_en[slotIdx_q] && (!blink_en[slotIdx_q] || blinkOn_q);
    anode_d  = 8'hFF;
    nibble_d = BlankCode;
    dp_d     = 1'b1;
    if (visible) begin
      anode_d[slotIdx_q] = 1'b0;
      nibble_d           = display_q[{slotIdx_q, 2'b00} +: 4];
      dp_d               = ~point[slotIdx_q];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prescCnt_q <= 16'd0;
      slotIdx_q  <= 3'd0;
      blinkCnt_q <= 16'd0;
      blinkOn_q  <= 1'b1;
      pending_q  <= AllBlank;
      display_q  <= AllBlank;
      busy_q     <= 1'b0;
      anode_q    <= 8'hFF;
      nibble_q   <= BlankCode;
      dp_q       <= 1'b1;
    end else begin
      prescCnt_q <= prescCnt_d;
      slotIdx_q  <= slotIdx_d;
      blinkCnt_q <= blinkCnt_d;
      blinkOn_q  <= blinkOn_d;
      pending_q  <= pending_d;
      display_q  <= display_d;
      busy_q     <= busy_d;
      anode_q    <= anode_d;
      nibble_q   <= nibble_d;
      dp_q       <= dp_d;
    end
  end

  assign busy   = busy_q;
  assign anode  = anode_q;
  assign nibble = nibble_q;
  assign dp     = dp_q;

endmodule

// File: tb/tb_display_mux_ctrl.sv
// ---------------------------------------------------------------------------
// tb_display_mux_ctrl
//
// Bench for display_mux_ctrl with PRESCALE=4 and BLINK_SLOTS=8. Each cycle
// the expected {busy, anode, nibble, dp} is derived from a timing model
// based on cycles since reset. It is queued when the stimulus is applied
// and popped after the clock edge to be compared with the outputs.
// ---------------------------------------------------------------------------
module tb_display_mux_ctrl;

  localparam int P     = 4;
  localparam int B     = 8;
  localparam int FRAME = 8 * P;

  logic        clock;
  logic        reset_n;
  logic [31:0] value;
  logic        load;
  logic [7:0]  digit_en;
  logic [7:0]  point;
  logic [7:0]  blink_en;
  logic        busy;
  logic [3:0]  nibble;
  logic [7:0]  anode;
  logic        dp;

  int tests;
  int failures;

  // Reference state: cycles since reset release, pending, display, busy.
  int          cyc;
  logic [31:0] mPend;
  logic [31:0] mDisp;
  logic        mBusy;
  logic [13:0] sb[$];

  display_mux_ctrl #(.PRESCALE(P), .BLINK_SLOTS(B)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .value    (value),
    .load     (load),
    .digit_en (digit_en),
    .point    (point),
    .blink_en (blink_en),
    .busy     (busy),
    .nibble   (nibble),
    .anode    (anode),
    .dp       (dp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Clears the reference state to its reset contents.
  task automatic modelReset();
    cyc   = 0;
    mPend = 32'hEEEE_EEEE;
    mDisp = 32'hEEEE_EEEE;
    mBusy = 1'b0;
    sb.delete();
  endtask

  // Queues the outputs expected after the next edge for the current inputs,
  // updates the reference state, then moves to 1 time unit after the edge.
  task automatic applyStimulus();
    int          ticks;
    int          s;
    logic        phaseOn;
    logic        vis;
    logic        commit;
    logic [7:0]  an;
    logic [3:0]  nb;
    logic        d;
    ticks   = cyc / P;
    s       = ticks % 8;
    phaseOn = ((ticks / B) % 2) == 0;
    vis     = digit_en[s] && (!blink_en[s] || phaseOn);
    an = 8'hFF;
    nb = 4'hE;
    d  = 1'b1;
    if (vis) begin
      an[s] = 1'b0;
      nb    = mDisp[4*s +: 4];
      d     = ~point[s];
    end
    commit = ((cyc % FRAME) == FRAME - 1) && mBusy;
    if (commit) mDisp = mPend;
    if (load) begin
      mPend = value;
      mBusy = 1'b1;
    end else if (commit) begin
      mBusy = 1'b0;
    end
    cyc++;
    sb.push_back({mBusy, an, nb, d});
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [13:0] got;
    reset_n  = 1'b0;
    load     = 1'b0;
    value    = 32'h0;
    digit_en = 8'hFF;
    point    = 8'h00;
    blink_en = 8'h00;
    repeat (3) begin
      @(posedge clock);
      #1;
      got = {busy, anode, nibble, dp};
      tests++;
      if (got !== {1'b0, 8'hFF, 4'hE, 1'b1}) begin
        failures++;
        $display("[TB] FAIL reset_state got=%h exp=%h", got, {1'b0, 8'hFF, 4'hE, 1'b1});
      end
    end
    reset_n = 1'b1;
    modelReset();
  endtask

  task automatic test_load_commit();
    logic [13:0] got;
    logic [13:0] exp;
    for (int i = 0; i < 3 * FRAME; i++) begin
      load  = (i == 2);
      value = (i == 2) ? 32'h0123_4567 : 32'h0;
      applyStimulus();
      got = {busy, anode, nibble, dp};
      exp = sb.pop_front();
      tests++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL load_commit cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_overwrite();
    logic [13:0] got;
    logic [13:0] exp;
    int          sawA;
    sawA = 0;
    while ((cyc % FRAME) != 2) begin
      applyStimulus();
      got = {busy, anode, nibble, dp};
      exp = sb.pop_front();
      tests++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL overwrite_align cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
    end
    for (int i = 0; i < 3 * FRAME; i++) begin
      load  = (i == 0) || (i == 2);
      value = (i == 0) ? 32'hAAAA_0000 : 32'hFBDC_0000;
      applyStimulus();
      got = {busy, anode, nibble, dp};
      exp = sb.pop_front();
      tests++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL overwrite cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
      if ((anode[7:4] != 4'hF) && (nibble == 4'hA)) sawA++;
    end
    load = 1'b0;
    tests++;
    if (sawA !== 0) begin
      failures++;
      $display("[TB] FAIL overwrite_no_A got=%0d exp=0", sawA);
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] got;
    logic [13:0] exp;
    for (int i = 0; i < 2 * FRAME + 1; i++) begin
      load  = ((cyc % FRAME) == 5) && (i < FRAME);
      value = 32'h1111_1111;
      if (!load && (cyc % FRAME) == FRAME - 1 && mBusy) begin
        load  = 1'b1;
        value = 32'h2222_2222;
      end
      applyStimulus();
      got = {busy, anode, nibble, dp};
      exp = sb.pop_front();
      tests++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
      if (load && value == 32'h2222_2222) begin
        tests++;
        if (busy !== 1'b1) begin
          failures++;
          $display("[TB] FAIL back_to_back_busy got=%b exp=1", busy);
        end
      end
      if (load && value == 32'h2222_2222) i = 2 * FRAME;
    end
    load = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      applyStimulus();
      got = {busy, anode, nibble, dp};
      exp = sb.pop_front();
      tests++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL back_to_back_after cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
    end
  endtask

  task automatic test_blink();
    logic [13:0] got;
    logic [13:0] exp;
    int          multi;
    multi    = 0;
    blink_en = 8'h01;
    for (int i = 0; i < 4 * FRAME; i++) begin
      applyStimulus();
      got = {busy, anode, nibble, dp};
      exp = sb.pop_front();
      tests++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL blink cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
      if ($countones(~anode) > 1) multi++;
    end
    blink_en = 8'h00;
    tests++;
    if (multi !== 0) begin
      failures++;
      $display("[TB] FAIL one_anode got=%0d exp=0", multi);
    end
  endtask

  task automatic test_digit_point();
    logic [13:0] got;
    logic [13:0] exp;
    int          dpLow;
    dpLow    = 0;
    digit_en = 8'h0F;
    point    = 8'h10;
    for (int i = 0; i < FRAME + 4; i++) begin
      applyStimulus();
      got = {busy, anode, nibble, dp};
      exp = sb.pop_front();
      tests++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL digit_en cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
      if (dp == 1'b0) dpLow++;
    end
    tests++;
    if (dpLow !== 0) begin
      failures++;
      $display("[TB] FAIL dp_dark got=%0d exp=0", dpLow);
    end
    point = 8'h01;
    for (int i = 0; i < FRAME + 4; i++) begin
      applyStimulus();
      got = {busy, anode, nibble, dp};
      exp = sb.pop_front();
      tests++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL point cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
      tests++;
      if ((dp == 1'b0) !== (anode == 8'hFE)) begin
        failures++;
        $display("[TB] FAIL dp_only_digit0 anode=%h dp=%b", anode, dp);
      end
    end
    digit_en = 8'hFF;
    point    = 8'h00;
  endtask

  task automatic test_reset_mid();
    logic [13:0] got;
    logic [13:0] exp;
    while ((cyc % P) != 1) begin
      applyStimulus();
      got = {busy, anode, nibble, dp};
      exp = sb.pop_front();
      tests++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL reset_mid_align cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
    end
    load  = 1'b1;
    value = 32'h9876_5432;
    applyStimulus();
    load = 1'b0;
    got = {busy, anode, nibble, dp};
    exp = sb.pop_front();
    tests++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL reset_mid_load got=%h exp=%h", got, exp);
    end
    #2;
    reset_n = 1'b0;
    #1;
    got = {busy, anode, nibble, dp};
    tests++;
    if (got !== {1'b0, 8'hFF, 4'hE, 1'b1}) begin
      failures++;
      $display("[TB] FAIL reset_mid_async got=%h exp=%h", got, {1'b0, 8'hFF, 4'hE, 1'b1});
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    modelReset();
    for (int i = 0; i < 2 * FRAME; i++) begin
      applyStimulus();
      got = {busy, anode, nibble, dp};
      exp = sb.pop_front();
      tests++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL reset_mid_blank cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
      tests++;
      if (nibble !== 4'hE) begin
        failures++;
        $display("[TB] FAIL reset_mid_nibble got=%h exp=e", nibble);
      end
    end
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    modelReset();
    test_reset();
    test_load_commit();
    test_overwrite();
    test_back_to_back();
    test_blink();
    test_digit_point();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
